// File: rtl/rom_read_arbiter_if.sv
// Requester-side bus of the fixed-memory ROM read arbiter: two read ports sharing one data return.
interface rom_read_arbiter_if;
  logic        req_a;
  logic [16:0] addr_a;
  logic        ack_a;
  logic        req_b;
  logic [16:0] addr_b;
  logic        ack_b;
  logic [15:0] rd_data;
  logic        grant_b;
  logic        busy;

  modport master (
    output req_a, addr_a, req_b, addr_b,
    input  ack_a, ack_b, rd_data, grant_b, busy
  );

  modport slave (
    input  req_a, addr_a, req_b, addr_b,
    output ack_a, ack_b, rd_data, grant_b, busy
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Sequences read cycles into the asynchronous 128Kx16 fixed-memory ROM and shares it between
// the AGC core fetch (port A, priority) and the monitor/debug reader (port B).
module rom_read_arbiter #(
  parameter int ACCESS_CYCLES  = 5,
  parameter int RECOVER_CYCLES = 1,
  parameter int MAX_SKIP       = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  rom_read_arbiter_if.slave    bus,
  output logic                 rom_ce_,
  output logic                 rom_oe_,
  output logic                 rom_we_,
  output logic [16:0]          rom_a,
  input  logic [15:0]          rom_dq
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    DONE    = 3'd3,
    RECOVER = 3'd4
  } state_t;

  localparam int CNT_MAX = (ACCESS_CYCLES > RECOVER_CYCLES) ? ACCESS_CYCLES : RECOVER_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 32'sd1);
  localparam int SW      = $clog2(MAX_SKIP + 32'sd2);
  localparam logic [CW-1:0] ACC_LAST   = CW'(ACCESS_CYCLES - 32'sd1);
  localparam logic [CW-1:0] REC_LAST   = CW'((RECOVER_CYCLES > 32'sd0) ? RECOVER_CYCLES - 32'sd1 : 32'sd0);
  localparam logic [SW-1:0] SKIP_LIMIT = SW'(MAX_SKIP);
  localparam logic          SKIP_EN    = (MAX_SKIP != 32'sd0);

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [SW-1:0]   skip_r, skip_s;
  logic            b_wins_s;
  logic [16:0]     addr_s;
  logic            grant_s;
  logic [15:0]     data_s;
  logic            ce_s, oe_s, ack_a_s, ack_b_s, busy_s;

  // The ROM is read-only from this side; the write strobe is a constant, so it cannot glitch.
  assign rom_we_ = 1'b1;

  // Next-state, arbitration and next-output decode; outputs are derived from the next state so
  // every strobe leaves a single flop.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    skip_s   = skip_r;
    addr_s   = rom_a;
    grant_s  = bus.grant_b;
    data_s   = bus.rd_data;
    b_wins_s = bus.req_b && (!bus.req_a || (SKIP_EN && (skip_r == SKIP_LIMIT)));
    case (state_r)
      IDLE: begin
        if (bus.req_a || bus.req_b) begin
          state_s = SETUP;
          if (b_wins_s) begin
            grant_s = 1'b1;
            addr_s  = bus.addr_b;
            skip_s  = '0;
          end else begin
            grant_s = 1'b0;
            addr_s  = bus.addr_a;
            // Saturate so strict-priority mode never wraps the counter.
            if (!bus.req_b) begin
              skip_s = '0;
            end else if (skip_r == SKIP_LIMIT) begin
              skip_s = skip_r;
            end else begin
              skip_s = skip_r + SW'(1);
            end
          end
        end else begin
          skip_s = '0;
        end
      end
      SETUP: begin
        state_s = ACCESS;
        cnt_s   = '0;
      end
      ACCESS: begin
        if (cnt_r == ACC_LAST) begin
          state_s = DONE;
          data_s  = rom_dq;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      DONE: begin
        if (RECOVER_CYCLES == 32'sd0) begin
          state_s = IDLE;
        end else begin
          state_s = RECOVER;
          cnt_s   = '0;
        end
      end
      RECOVER: begin
        if (cnt_r == REC_LAST) begin
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    ce_s    = !((state_s == SETUP) || (state_s == ACCESS));
    oe_s    = (state_s != ACCESS);
    ack_a_s = (state_s == DONE) && !grant_s;
    ack_b_s = (state_s == DONE) && grant_s;
    busy_s  = (state_s != IDLE);
  end

  // FSM state, phase counter and port-B starvation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      skip_r  <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      skip_r  <= skip_s;
    end
  end

  // Registered ROM strobes, address and requester-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_ce_     <= 1'b1;
      rom_oe_     <= 1'b1;
      rom_a       <= 17'h0_0000;
      bus.rd_data <= 16'h0000;
      bus.ack_a   <= 1'b0;
      bus.ack_b   <= 1'b0;
      bus.grant_b <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      rom_ce_     <= ce_s;
      rom_oe_     <= oe_s;
      rom_a       <= addr_s;
      bus.rd_data <= data_s;
      bus.ack_a   <= ack_a_s;
      bus.ack_b   <= ack_b_s;
      bus.grant_b <= grant_s;
      bus.busy    <= busy_s;
    end
  end

endmodule
